// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types for the 16-bit 5-stage pipeline: hazard FSM states,
// default register-address width and the ALU opcode encoding.
package hazard_stall_ctrl_pkg;

  localparam int REG_AW_DEF = 3;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hz_state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-detection bundle between the pipeline datapath (master) and the
// stall/flush controller (slave).
interface hazard_stall_ctrl_if
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] ex_wa;
  logic              ex_mem_read;
  logic              ex_branch_taken;
  logic              ex_jump;
  logic              mem_req;
  logic              mem_ready;
  logic              pc_hold;
  logic              if_id_hold;
  logic              id_ex_hold;
  logic              ex_mem_hold;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              mem_wb_flush;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_wa, ex_mem_read,
           ex_branch_taken, ex_jump, mem_req, mem_ready,
    input  pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
           if_id_flush, id_ex_flush, mem_wb_flush
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_wa, ex_mem_read,
           ex_branch_taken, ex_jump, mem_req, mem_ready,
    output pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
           if_id_flush, id_ex_flush, mem_wb_flush
  );
endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_reg;

  // Count up, sticking at all-ones; clear overrides a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller: load-use bubbles, branch/jump flushes and
// data-memory wait freezes, plus stall-cycle and flush-event counters.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_AW            = REG_AW_DEF,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic               clk,
  input  logic               reset,
  hazard_stall_ctrl_if.slave hz,
  input  logic               clr_cnt,
  output logic [1:0]         ctrl_state,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);
  localparam logic [REG_AW-1:0] R0       = '0;
  localparam logic [2:0]        BUB_LOAD = 3'(LOAD_STALL_CYCLES - 1);

  hz_state_t  state_reg, state_next;
  hz_state_t  saved_reg, saved_next;
  logic [2:0] bub_reg, bub_next;

  logic memwait, redirect, lu;
  logic pc_h, ifid_h, idex_h, exmem_h, ifid_f, idex_f, memwb_f, flush_evt;

  assign memwait  = hz.mem_req & ~hz.mem_ready;
  assign redirect = hz.ex_branch_taken | hz.ex_jump;
  assign lu       = hz.ex_mem_read && (hz.ex_wa != R0) &&
                    ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_wa)) ||
                     (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_wa)));

  // State, saved-return-state and remaining-bubble registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RUN;
      saved_reg <= RUN;
      bub_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      saved_reg <= saved_next;
      bub_reg   <= bub_next;
    end
  end

  // Next state and raw controls; memory wait outranks redirect outranks load-use.
  always_comb begin
    state_next = state_reg;
    saved_next = saved_reg;
    bub_next   = bub_reg;
    pc_h       = 1'b0;
    ifid_h     = 1'b0;
    idex_h     = 1'b0;
    exmem_h    = 1'b0;
    ifid_f     = 1'b0;
    idex_f     = 1'b0;
    memwb_f    = 1'b0;
    flush_evt  = 1'b0;
    if (memwait) begin
      pc_h    = 1'b1;
      ifid_h  = 1'b1;
      idex_h  = 1'b1;
      exmem_h = 1'b1;
      memwb_f = 1'b1;
      if (state_reg != MEM_WAIT) begin
        saved_next = state_reg;
        state_next = MEM_WAIT;
      end
    end else begin
      case (state_reg)
        RUN: begin
          if (redirect) begin
            // The hazarding ID instruction is on the wrong path; flushing it is enough.
            ifid_f    = 1'b1;
            idex_f    = 1'b1;
            flush_evt = 1'b1;
          end else if (lu) begin
            pc_h   = 1'b1;
            ifid_h = 1'b1;
            idex_f = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_next = LOAD_STALL;
              bub_next   = BUB_LOAD;
            end
          end
        end
        LOAD_STALL: begin
          pc_h     = 1'b1;
          ifid_h   = 1'b1;
          idex_f   = 1'b1;
          bub_next = bub_reg - 3'd1;
          if (bub_reg <= 3'd1) begin
            state_next = RUN;
          end
        end
        MEM_WAIT: begin
          state_next = saved_reg;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // Controls are forced inactive while reset is held low.
  assign hz.pc_hold      = pc_h    & reset;
  assign hz.if_id_hold   = ifid_h  & reset;
  assign hz.id_ex_hold   = idex_h  & reset;
  assign hz.ex_mem_hold  = exmem_h & reset;
  assign hz.if_id_flush  = ifid_f  & reset;
  assign hz.id_ex_flush  = idex_f  & reset;
  assign hz.mem_wb_flush = memwb_f & reset;
  assign ctrl_state      = state_reg;

  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc[0] = pc_h & reset;
  assign cnt_inc[1] = flush_evt & reset;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (cnt_inc[gi]),
      .clr   (clr_cnt),
      .cnt   (cnt_val[gi])
    );
  end

  assign stall_cnt = cnt_val[0];
  assign flush_cnt = cnt_val[1];
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: one instance with single-bubble load stalls,
// one with three-bubble load stalls; table vectors plus corner sequences.
module tb_hazard_stall_ctrl;
  typedef struct packed {
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       u1;
    logic       u2;
    logic [2:0] wa;
    logic       mrd;
    logic       br;
    logic       jmp;
    logic       mreq;
    logic       mrdy;
    logic       clr;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      st;
    logic [6:0] outs;
    logic [1:0] state;
  } vec_t;

  typedef struct {
    string      name;
    bit         sel;
    logic [6:0] outs;
    logic [1:0] state;
  } exp_t;

  // {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush, mem_wb_flush}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1100010;
  localparam logic [6:0] O_MW   = 7'b1111001;
  localparam logic [6:0] O_BR   = 7'b0000110;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  stim_t s1 = '0;
  stim_t s3 = '0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_AW(3)) if1 ();
  hazard_stall_ctrl_if #(.REG_AW(3)) if3 ();

  assign if1.id_rs1 = s1.rs1;  assign if1.id_rs2 = s1.rs2;
  assign if1.id_use_rs1 = s1.u1;  assign if1.id_use_rs2 = s1.u2;
  assign if1.ex_wa = s1.wa;  assign if1.ex_mem_read = s1.mrd;
  assign if1.ex_branch_taken = s1.br;  assign if1.ex_jump = s1.jmp;
  assign if1.mem_req = s1.mreq;  assign if1.mem_ready = s1.mrdy;
  assign if3.id_rs1 = s3.rs1;  assign if3.id_rs2 = s3.rs2;
  assign if3.id_use_rs1 = s3.u1;  assign if3.id_use_rs2 = s3.u2;
  assign if3.ex_wa = s3.wa;  assign if3.ex_mem_read = s3.mrd;
  assign if3.ex_branch_taken = s3.br;  assign if3.ex_jump = s3.jmp;
  assign if3.mem_req = s3.mreq;  assign if3.mem_ready = s3.mrdy;

  logic [1:0]  st1, st3;
  logic [15:0] sc1, fc1, sc3, fc3;
  logic [6:0]  out1, out3;

  assign out1 = {if1.pc_hold, if1.if_id_hold, if1.id_ex_hold, if1.ex_mem_hold,
                 if1.if_id_flush, if1.id_ex_flush, if1.mem_wb_flush};
  assign out3 = {if3.pc_hold, if3.if_id_hold, if3.id_ex_hold, if3.ex_mem_hold,
                 if3.if_id_flush, if3.id_ex_flush, if3.mem_wb_flush};

  hazard_stall_ctrl #(.REG_AW(3), .LOAD_STALL_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset_n), .hz(if1.slave), .clr_cnt(s1.clr),
    .ctrl_state(st1), .stall_cnt(sc1), .flush_cnt(fc1)
  );

  hazard_stall_ctrl #(.REG_AW(3), .LOAD_STALL_CYCLES(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(reset_n), .hz(if3.slave), .clr_cnt(s3.clr),
    .ctrl_state(st3), .stall_cnt(sc3), .flush_cnt(fc3)
  );

  function automatic stim_t mk(input logic [2:0] rs1, input logic [2:0] rs2,
                               input logic u1, input logic u2, input logic [2:0] wa,
                               input logic mrd, input logic br, input logic jmp,
                               input logic mreq, input logic mrdy);
    stim_t s;
    s = '{rs1: rs1, rs2: rs2, u1: u1, u2: u2, wa: wa, mrd: mrd, br: br,
          jmp: jmp, mreq: mreq, mrdy: mrdy, clr: 1'b0};
    return s;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
  task automatic step(input string nm, input bit sel, input stim_t st,
                      input logic [6:0] eo, input logic [1:0] es);
    exp_t e;
    if (sel) s3 = st; else s1 = st;
    e.name = nm; e.sel = sel; e.outs = eo; e.state = es;
    sbq.push_back(e);
    @(negedge clk);
    if (sbq.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sbq.pop_front();
      check({e.name, ".outs"}, 32'(e.sel ? out3 : out1), 32'(e.outs));
      check({e.name, ".state"}, 32'(e.sel ? st3 : st1), 32'(e.state));
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vt[12];
  stim_t idle, lu3, mw, mrdy1;

  initial begin
    idle  = mk(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lu3   = mk(3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    mw    = mk(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    mrdy1 = mk(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    vt[0]  = '{"idle",       idle, O_NONE, 2'd0};
    vt[1]  = '{"lu_rs1",     lu3,  O_LU,   2'd0};
    vt[2]  = '{"lu_rs2",     mk(3'd1, 3'd5, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), O_LU, 2'd0};
    vt[3]  = '{"r0_no_lu",   mk(3'd0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), O_NONE, 2'd0};
    vt[4]  = '{"rs2_unused", mk(3'd1, 3'd4, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), O_NONE, 2'd0};
    vt[5]  = '{"not_load",   mk(3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), O_NONE, 2'd0};
    vt[6]  = '{"br_and_lu",  mk(3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), O_BR, 2'd0};
    vt[7]  = '{"jump",       mk(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), O_BR, 2'd0};
    vt[8]  = '{"memwait",    mk(3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0), O_MW, 2'd0};
    vt[9]  = '{"mem_done",   mrdy1, O_NONE, 2'd2};
    vt[10] = '{"back_run",   idle,  O_NONE, 2'd0};
    vt[11] = '{"lu_memrdy",  mk(3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1), O_LU, 2'd0};

    // Reset state, with a memory wait pending to prove the gating.
    s1 = mw; s3 = mw;
    @(posedge clk); #1;
    check("rst.outs1", 32'(out1), 32'(O_NONE));
    check("rst.outs3", 32'(out3), 32'(O_NONE));
    check("rst.state1", 32'(st1), 32'd0);
    check("rst.stall1", 32'(sc1), 32'd0);
    check("rst.flush3", 32'(fc3), 32'd0);
    s1 = idle; s3 = idle;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single-bubble instance: table of single-cycle patterns.
    for (int i = 0; i < 12; i++) begin
      step(vt[i].name, 1'b0, vt[i].st, vt[i].outs, vt[i].state);
    end
    check("tbl.stall_cnt", 32'(sc1), 32'd4);
    check("tbl.flush_cnt", 32'(fc1), 32'd2);

    // Three-bubble load-use stall.
    step("ls3.c0", 1'b1, lu3, O_LU, 2'd0);
    step("ls3.c1", 1'b1, lu3, O_LU, 2'd1);
    step("ls3.c2", 1'b1, lu3, O_LU, 2'd1);
    step("ls3.end", 1'b1, idle, O_NONE, 2'd0);
    check("ls3.stall_cnt", 32'(sc3), 32'd3);

    // Memory wait arriving mid load stall; bubble count must survive it.
    step("lsmw.lu", 1'b1, lu3, O_LU, 2'd0);
    step("lsmw.w0", 1'b1, mw, O_MW, 2'd1);
    step("lsmw.w1", 1'b1, mw, O_MW, 2'd2);
    step("lsmw.w2", 1'b1, mw, O_MW, 2'd2);
    step("lsmw.w3", 1'b1, mw, O_MW, 2'd2);
    step("lsmw.rdy", 1'b1, mrdy1, O_NONE, 2'd2);
    step("lsmw.b2", 1'b1, idle, O_LU, 2'd1);
    step("lsmw.b3", 1'b1, idle, O_LU, 2'd1);
    step("lsmw.end", 1'b1, idle, O_NONE, 2'd0);
    check("lsmw.stall_cnt", 32'(sc3), 32'd10);
    check("lsmw.flush_cnt", 32'(fc3), 32'd0);

    // Clear beats a same-cycle increment, then drive the stall counter to saturation.
    s1 = mw; s1.clr = 1'b1;
    @(posedge clk); #1;
    check("clr.override", 32'(sc1), 32'd0);
    check("clr.flush", 32'(fc1), 32'd0);
    s1 = mw;
    repeat (65534) @(posedge clk);
    #1;
    check("sat.pre", 32'(sc1), 32'h0000FFFE);
    repeat (3) @(posedge clk);
    #1;
    check("sat.hold", 32'(sc1), 32'h0000FFFF);
    step("sat.rdy", 1'b0, mrdy1, O_NONE, 2'd2);
    step("sat.run", 1'b0, idle, O_NONE, 2'd0);

    // Reset asserted while in MEM_WAIT with the wait still pending.
    s3 = mw;
    @(posedge clk); #1;
    check("mwrst.pre_state", 32'(st3), 32'd2);
    reset_n = 1'b0;
    #1;
    check("mwrst.outs", 32'(out3), 32'(O_NONE));
    check("mwrst.state", 32'(st3), 32'd0);
    check("mwrst.stall", 32'(sc3), 32'd0);
    @(posedge clk); #1;
    s3 = idle;
    reset_n = 1'b1;
    @(posedge clk); #1;
    step("mwrst.after", 1'b1, idle, O_NONE, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall/flush controller for the 16-bit 5-stage pipeline.
- Detects load-use hazards, taken branches/jumps in EX, and data-memory wait states.
- Drives the hold and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Keeps saturating performance counters for stall cycles and flush events.

Parameters:
REG_AW, 3, register-address width (8 architectural registers; r0 is hardwired zero)
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
id_rs1  in  REG_AW  source register 1 of the instruction in ID
id_rs2  in  REG_AW  source register 2 of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_wa  in  REG_AW  destination register of the instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX branch resolved as taken
ex_jump  in  1  EX instruction is a jump
mem_req  in  1  MEM stage has an active data-memory access
mem_ready  in  1  data memory completes the access this cycle
clr_cnt  in  1  synchronous clear of both counters
pc_hold  out  1  PC keeps its value
if_id_hold  out  1  IF/ID register keeps its value
id_ex_hold  out  1  ID/EX register keeps its value
ex_mem_hold  out  1  EX/MEM register keeps its value
if_id_flush  out  1  IF/ID loads a bubble at the next edge
id_ex_flush  out  1  ID/EX loads a bubble at the next edge
mem_wb_flush  out  1  MEM/WB loads a bubble at the next edge
ctrl_state  out  2  current FSM state, for debug
stall_cnt  out  CNT_W  stall-cycle counter
flush_cnt  out  CNT_W  branch/jump flush-event counter

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN; saved state=RUN; bubble counter=0; stall_cnt=0; flush_cnt=0.
  - All hold/flush outputs forced to 0 while reset is low.
- Hold semantics: hold=1 freezes the register; flush=1 takes precedence over the register's load and writes a bubble (all control bits 0).
- Combinational event terms:
  - memwait = mem_req & ~mem_ready
  - redirect = ex_branch_taken | ex_jump
  - lu = ex_mem_read & ex_wa!=0 & ((id_use_rs1 & id_rs1==ex_wa) | (id_use_rs2 & id_rs2==ex_wa))
- FSM states: RUN=0, LOAD_STALL=1, MEM_WAIT=2. Priority in every state: memwait > redirect > lu.
- Any state with memwait:
  - pc_hold, if_id_hold, id_ex_hold, ex_mem_hold = 1; mem_wb_flush=1.
  - If not already in MEM_WAIT, save the current state and enter MEM_WAIT.
- MEM_WAIT:
  - Outputs as for memwait while memwait=1; the bubble counter is frozen.
  - On the mem_ready=1 cycle: no holds; next state = saved state.
- RUN, redirect (no memwait):
  - if_id_flush=1, id_ex_flush=1, no holds; flush_cnt +1; stay in RUN.
  - A simultaneous lu is ignored: the hazarding instruction is flushed.
- RUN, lu (no memwait, no redirect):
  - pc_hold=1, if_id_hold=1, id_ex_flush=1 (bubble 1).
  - If LOAD_STALL_CYCLES>1: enter LOAD_STALL with counter=LOAD_STALL_CYCLES-1.
- LOAD_STALL, each cycle without memwait:
  - pc_hold, if_id_hold, id_ex_flush = 1; decrement the counter.
  - When the counter reaches 1, the next state is RUN.
  - redirect cannot occur here, because EX holds a bubble.
- Latency: all outputs are combinational from the inputs and the current state, and act at the next clk edge; no added cycle.
- Counters (both saturate at 2^CNT_W-1):
  - stall_cnt +1 on every cycle with pc_hold=1.
  - clr_cnt=1 clears both counters the next cycle, overriding any increment.
- Reset mid-stall returns the block to RUN immediately, with no residual holds.

Decomposition:
- Shared package: hz_state_t enum (RUN, LOAD_STALL, MEM_WAIT) and the default REG_AW value, alongside the existing ALU opcode typedef.
- One sub-module: sat_counter (CNT_W wide, inc and clr inputs, saturating). It is instantiated twice.

Test Plan:
- Load-use: ex_mem_read=1, ex_wa=3, id_rs1=3, id_use_rs1=1 -> pc_hold=1, if_id_hold=1, id_ex_flush=1 for exactly 1 cycle; stall_cnt=1.
- Same stimulus with LOAD_STALL_CYCLES=3 -> holds for 3 consecutive cycles; ctrl_state 0->1->1->0; stall_cnt=3.
- r0 and unused operand: ex_wa=0 matching id_rs1=0, or id_use_rs2=0 with a matching rs2 -> no hold; state stays RUN.
- Branch with simultaneous load-use: ex_branch_taken=1 and lu=1 -> if_id_flush=1, id_ex_flush=1, pc_hold=0; flush_cnt=1.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles during LOAD_STALL (counter=2) -> all holds and mem_wb_flush=1 for 4 cycles; then LOAD_STALL resumes with counter=2; stall_cnt +6 overall.
- Saturation and reset: preload stall_cnt to 0xFFFE, stall 3 cycles -> stall_cnt=0xFFFF; assert reset low mid-MEM_WAIT -> all outputs 0, ctrl_state=0.
